// File: rtl/fetch_unit_pkg.sv
// Shared constants for the cpu4 prefetch stage: reset fetch address and consume encodings.
// Saturating consume helper keeps over-consume from underflowing the queue.
package fetch_unit_pkg;

    localparam logic [15:0] FETCH_RESET_PC = 16'h000C;

    localparam logic [1:0] CONSUME_0 = 2'd0;
    localparam logic [1:0] CONSUME_1 = 2'd1;
    localparam logic [1:0] CONSUME_2 = 2'd2;
    localparam logic [1:0] CONSUME_3 = 2'd3;

    // Effective retire count: min(req, avail).
    function automatic logic [1:0] sat_consume(input logic [1:0] req, input logic [7:0] avail);
        if ({6'b0, req} > avail) begin
            return avail[1:0];
        end
        return req;
    endfunction

endpackage

// File: rtl/fetch_unit_prefetch_queue.sv
// Circular byte queue with push, pop of 0-3 bytes, clear, and masked peek at offsets 0-2.
// Zero-latency peek of registered state; caller must never push into a full queue.
module prefetch_queue #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [7:0]    push_dat_i,
    input  logic [1:0]    pop_n_i,
    output logic [CW-1:0] count_o,
    output logic [7:0]    peek0_o,
    output logic [7:0]    peek1_o,
    output logic [7:0]    peek2_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] p1, p2;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_n_i);
            tail_d  = tail_q + PW'(push_i);
            count_d = count_q + CW'(push_i) - CW'(pop_n_i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: every read is masked by count.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[tail_q] <= push_dat_i;
        end
    end

    always_comb begin
        p1      = head_q + PW'(1);
        p2      = head_q + PW'(2);
        peek0_o = (count_q > CW'(0)) ? mem_q[head_q] : 8'h00;
        peek1_o = (count_q > CW'(1)) ? mem_q[p1]     : 8'h00;
        peek2_o = (count_q > CW'(2)) ? mem_q[p2]     : 8'h00;
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Prefetch stage: streams ROM bytes into a queue and presents the next three to decode.
// Read issued the cycle a slot is guaranteed (incl. in-flight byte); jump flushes, first byte visible 3 cycles later.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic [ADDR_W-1:0]          rom_addr,
    output logic                       rom_rd,
    input  logic [7:0]                 rom_data,
    output logic [$clog2(DEPTH+1)-1:0] avail,
    output logic [7:0]                 b0,
    output logic [7:0]                 b1,
    output logic [7:0]                 b2,
    output logic [ADDR_W-1:0]          pc,
    input  logic [1:0]                 consume,
    input  logic                       jump,
    input  logic [ADDR_W-1:0]          jump_addr
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;

    logic [CW-1:0] avail_w;
    logic [1:0]    eff;
    logic [1:0]    pop_n;
    logic [CW:0]   level;
    logic          issue;
    logic          push;

    prefetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (jump),
        .push_i     (push),
        .push_dat_i (rom_data),
        .pop_n_i    (pop_n),
        .count_o    (avail_w),
        .peek0_o    (b0),
        .peek1_o    (b1),
        .peek2_o    (b2)
    );

    // Occupancy after this edge counts the returning byte, so an issue now always has a slot when it lands.
    always_comb begin
        eff   = sat_consume(consume, 8'(avail_w));
        level = (CW+1)'(avail_w) + (CW+1)'(inflight_q) - (CW+1)'(eff);
        issue = reset_n && !jump && (level < (CW+1)'(DEPTH));
        push  = inflight_q && !jump;
        pop_n = jump ? CONSUME_0 : eff;
    end

    always_comb begin
        faddr_d    = faddr_q;
        pc_d       = pc_q;
        inflight_d = 1'b0;
        if (jump) begin
            faddr_d = jump_addr;
            pc_d    = jump_addr;
        end else begin
            pc_d       = pc_q + ADDR_W'(eff);
            inflight_d = issue;
            if (issue) begin
                faddr_d = faddr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            faddr_q    <= RESET_PC;
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            faddr_q    <= faddr_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign rom_rd   = issue;
    assign rom_addr = faddr_q;
    assign avail    = avail_w;
    assign pc       = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fill, variable consume, jump kill, over-consume, wrap, async reset.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data;
    logic [2:0]  avail;
    logic [7:0]  b0, b1, b2;
    logic [15:0] pc;
    logic [1:0]  consume;
    logic        jump;
    logic [15:0] jump_addr;

    int total  = 0;
    int passed = 0;

    fetch_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rom_addr  (rom_addr),
        .rom_rd    (rom_rd),
        .rom_data  (rom_data),
        .avail     (avail),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .pc        (pc),
        .consume   (consume),
        .jump      (jump),
        .jump_addr (jump_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        case (a)
            16'h000C: return 8'h31;
            16'h000D: return 8'hE0;
            16'h000E: return 8'h8F;
            16'h000F: return 8'h44;
            16'h0010: return 8'h55;
            16'h0011: return 8'h66;
            16'h0012: return 8'h77;
            16'h0100: return 8'hA1;
            16'h0101: return 8'hA2;
            16'h0102: return 8'hA3;
            16'hFFFE: return 8'hAA;
            16'hFFFF: return 8'hBB;
            16'h0000: return 8'hCC;
            16'h0001: return 8'hDD;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) begin
        rom_data <= rom_rd ? rom_fn(rom_addr) : 8'hEE;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One cycle: drive inputs just after the falling edge, then let combinational outputs settle.
    task automatic step(input logic [1:0] c, input logic j, input logic [15:0] ja);
        @(negedge clk);
        consume   = c;
        jump      = j;
        jump_addr = ja;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        consume   = CONSUME_0;
        jump      = 1'b0;
        jump_addr = 16'h0000;
        #12;
        chk("rst_rom_rd", 16'(rom_rd), 16'h0000);
        chk("rst_rom_addr", rom_addr, 16'h000C);
        chk("rst_avail", 16'(avail), 16'h0000);
        chk("rst_b0", 16'(b0), 16'h0000);
        chk("rst_pc", pc, 16'h000C);

        // Fill from reset
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("c0_rd", 16'(rom_rd), 16'h0001);
        chk("c0_addr", rom_addr, 16'h000C);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("c1_addr", rom_addr, 16'h000D);
        chk("c1_rd", 16'(rom_rd), 16'h0001);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("c2_avail", 16'(avail), 16'h0001);
        chk("c2_b0", 16'(b0), 16'h0031);
        chk("c2_addr", rom_addr, 16'h000E);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("c3_addr", rom_addr, 16'h000F);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("c4_rd", 16'(rom_rd), 16'h0000);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("full_avail", 16'(avail), 16'h0004);
        chk("full_rd", 16'(rom_rd), 16'h0000);
        chk("full_b0", 16'(b0), 16'h0031);
        chk("full_b1", 16'(b1), 16'h00E0);
        chk("full_b2", 16'(b2), 16'h008F);
        chk("full_pc", pc, 16'h000C);

        // Consume 2 from full: refill read issues in the same cycle
        step(CONSUME_2, 1'b0, 16'h0);
        chk("c2_resume_rd", 16'(rom_rd), 16'h0001);
        chk("c2_resume_addr", rom_addr, 16'h0010);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("cons2_pc", pc, 16'h000E);
        chk("cons2_b0", 16'(b0), 16'h008F);
        chk("cons2_b1", 16'(b1), 16'h0044);
        chk("cons2_avail", 16'(avail), 16'h0002);
        step(CONSUME_3, 1'b0, 16'h0);
        chk("refill_avail", 16'(avail), 16'h0003);
        chk("refill_b2", 16'(b2), 16'h0055);
        chk("cons3_addr", rom_addr, 16'h0012);
        step(CONSUME_0, 1'b1, 16'h0100);
        chk("cons3_pc", pc, 16'h0011);
        chk("cons3_b0", 16'(b0), 16'h0066);
        chk("cons3_avail", 16'(avail), 16'h0001);
        chk("jump_no_rd", 16'(rom_rd), 16'h0000);

        // After jump: the 0012 read is discarded; over-consume on an empty queue
        step(CONSUME_3, 1'b0, 16'h0);
        chk("j1_avail", 16'(avail), 16'h0000);
        chk("j1_pc", pc, 16'h0100);
        chk("j1_b0_mask", 16'(b0), 16'h0000);
        chk("j1_rd", 16'(rom_rd), 16'h0001);
        chk("j1_addr", rom_addr, 16'h0100);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("j2_pc_hold", pc, 16'h0100);
        chk("j2_avail", 16'(avail), 16'h0000);
        step(CONSUME_3, 1'b0, 16'h0);
        chk("j3_avail", 16'(avail), 16'h0001);
        chk("j3_b0", 16'(b0), 16'h00A1);
        chk("j3_pc", pc, 16'h0100);
        chk("j3_b1_mask", 16'(b1), 16'h0000);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("ovc_pc", pc, 16'h0101);
        chk("ovc_avail", 16'(avail), 16'h0001);
        chk("ovc_b0", 16'(b0), 16'h00A2);
        chk("ovc_b1_mask", 16'(b1), 16'h0000);
        chk("ovc_b2_mask", 16'(b2), 16'h0000);

        // Address wrap
        step(CONSUME_0, 1'b1, 16'hFFFE);
        chk("wj_no_rd", 16'(rom_rd), 16'h0000);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("w1_addr", rom_addr, 16'hFFFE);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("w2_addr", rom_addr, 16'hFFFF);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("w3_addr", rom_addr, 16'h0000);
        chk("w3_b0", 16'(b0), 16'h00AA);
        chk("w3_pc", pc, 16'hFFFE);
        step(CONSUME_0, 1'b0, 16'h0);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("w5_b2", 16'(b2), 16'h00CC);
        step(CONSUME_2, 1'b0, 16'h0);
        chk("w6_avail", 16'(avail), 16'h0004);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_b0", 16'(b0), 16'h00CC);
        chk("wrap_b1", 16'(b1), 16'h00DD);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("pre_rst_avail", 16'(avail), 16'h0003);

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_avail", 16'(avail), 16'h0000);
        chk("arst_rd", 16'(rom_rd), 16'h0000);
        chk("arst_pc", pc, 16'h000C);
        chk("arst_b0", 16'(b0), 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_rd", 16'(rom_rd), 16'h0001);
        chk("rel_addr", rom_addr, 16'h000C);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("rel1_addr", rom_addr, 16'h000D);
        step(CONSUME_0, 1'b0, 16'h0);
        chk("rel2_avail", 16'(avail), 16'h0001);
        chk("rel2_b0", 16'(b0), 16'h0031);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Byte-wide instruction prefetch stage sitting directly upstream of the cpu4 processor core. It streams program bytes from the synchronous program ROM into a small queue and presents the next three bytes (opcode, second, third) to the core's decode state machine. The core consumes 0–3 bytes per cycle; a jump flushes the queue and restarts fetching at a new address.

## Interface
- `ADDR_W`, 16: program address width.
- `DEPTH`, 4: queue depth in bytes; power of two, at least 4.
- `RESET_PC`, 16'h000C: first fetch address after reset.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  ADDR_W  ROM read address.
- `rom_rd`  out  1  ROM read strobe.
- `rom_data`  in  8  ROM data; valid in the cycle after `rom_rd`.
- `avail`  out  $clog2(DEPTH+1)  number of valid queued bytes.
- `b0`, `b1`, `b2`  out  8 each  queue bytes at offsets 0, 1 and 2. Each reads 8'h00 when its offset is at or beyond `avail`.
- `pc`  out  ADDR_W  address of `b0`.
- `consume`  in  2  bytes retired by the core this cycle (0–3).
- `jump`  in  1  flush request.
- `jump_addr`  in  ADDR_W  new fetch and `pc` address.

## Operation
- **Reset values:** `rom_rd`=0, `rom_addr`=RESET_PC, `avail`=0, `b0`–`b2`=8'h00, `pc`=RESET_PC. Fetch address `faddr`=RESET_PC, in-flight flag `inflight`=0.
- **Fetch rule:** assert `rom_rd` with `rom_addr`=`faddr` when `avail` + `inflight` − `consume` (effective) < DEPTH and `jump`=0. On issue, `faddr`++ and `inflight`=1 for the next cycle.
- At most one read is issued per cycle. Reads are pipelined, so back-to-back issue gives 1 byte/cycle.
- **Return:** when `inflight`=1, `rom_data` is pushed at the queue tail at the clock edge, unless that read was killed by a jump.
- **Consume:** the effective count is min(`consume`, `avail`), so over-consume saturates and never underflows. `pc` advances by the effective count.
- **Simultaneous push and pop:** new `avail` = `avail` + push − effective consume. A byte pushed this cycle is visible at offset `avail`−consume next cycle.
- **Jump:** has priority over consume, push and issue. At the edge: queue cleared, `avail`=0, `pc`=`faddr`=`jump_addr`. Any read outstanding in the jump cycle is killed and its data discarded. No `rom_rd` is issued in the jump cycle; fetching resumes the next cycle.
- **Address arithmetic:** modulo 2^ADDR_W; `faddr` and `pc` wrap from all-ones to 0 with no error.
- **Reset mid-operation:** asynchronously returns every register to its reset value. Returning ROM data is ignored.

## Timing
- After `reset_n` rises:
  - cycle 0: `rom_rd`=1, `rom_addr`=RESET_PC.
  - cycle 1: ROM drives the data; `rom_rd`=1, `rom_addr`=RESET_PC+1.
  - cycle 2: `avail`=1, `b0`=byte[RESET_PC].
- Jump-to-first-byte latency: jump asserted in cycle J; first read in J+1; byte visible (`avail`=1) in J+3.
- Queue full (`avail`=DEPTH, no consume): `rom_rd`=0. Reads resume in the same cycle that `consume` frees a slot, accounting for the in-flight byte.
- All outputs are registered, or are combinational decodes of registered state (`b0`–`b2` masking only). There is no combinational path from `consume`, `jump` or `rom_data` to any output except `rom_rd`/`rom_addr`, which depend on `consume` and `jump`.

## Structure
- Constants go in shared `fetch.vh`, included like `alu.vh` and `states.vh`: RESET_PC default and the consume encodings (CONSUME_0..CONSUME_3).
- One natural sub-module: `prefetch_queue`.
  - Circular byte buffer of DEPTH entries, with head/tail pointers of $clog2(DEPTH) bits plus a count.
  - Push, pop-N (0–3) and clear.
  - Peek at offsets 0–2 with masking.
- `fetch_unit` holds `faddr`, `pc`, `inflight` and the issue logic.

## Test plan
- **Reset and fill:** ROM[000C..000F]=31 E0 8F 44, `consume`=0. Required: `rom_addr` 000C,000D,000E,000F on consecutive cycles. `avail` reaches 4, then `rom_rd`=0. `b0`/`b1`/`b2`=31/E0/8F, `pc`=000C.
- **Variable consume:** from the full state, consume 2. Next cycle: `pc`=000E, `b0`=8F, `b1`=44, `avail`=3 (includes refill byte ROM[0010]) on the following cycle. Then consume 3: `pc`=0011.
- **Jump with read in flight:** assert `jump` with `jump_addr`=0100 while a read of 0012 is outstanding. Required: ROM[0012] never appears. `rom_addr`=0100 in J+1; `avail`=1, `b0`=ROM[0100], `pc`=0100 in J+3.
- **Over-consume and masking:** with `avail`=1, drive `consume`=3. Required: `avail`=0 next cycle, `pc` +1 only, `b0`–`b2`=00.
- **Address wrap:** jump to FFFE with ROM[FFFE]=AA, ROM[FFFF]=BB, ROM[0000]=CC. Required: `rom_addr` sequence FFFE, FFFF, 0000. After consume 2, `pc`=0000 and `b0`=CC.
- **Asynchronous reset mid-stream:** pulse `reset_n` low between edges while `avail`=3. Required: immediately `avail`=0, `rom_rd`=0, `pc`=000C. After release, refetch starts at 000C.
